candidate_generator: RTL and testbench

Upstream feeder for the brute-force cracking engine. Enumerates every fixed-length candidate password whose first character lies in a programmed charset-index range. Emits candidates as ASCII over a valid/ready stream, one per cycle at full throughput. Nine instances, programmed 0–3, 4–7, …, 32–35, split the full 36-character keyspace across parallel comparator stages. The downstream comparator asserts `abort` on a match.

---
 rtl/candidate_generator.sv | 143 ++++++++++++++
 tb/tb_candidate_generator.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/candidate_generator.sv
// Enumerates fixed-length ASCII candidate passwords whose first character lies in
// a programmed charset-index range, streaming one per cycle over valid/ready.
module candidate_generator #(
  parameter int NUM_CHARS    = 4,
  parameter int CHARSET_SIZE = 36
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [5:0]             from,
  input  logic [5:0]             to,
  input  logic                   abort,
  input  logic                   cand_ready,
  output logic                   cand_valid,
  output logic [8*NUM_CHARS-1:0] candidate,
  output logic                   cand_last,
  output logic                   busy,
  output logic                   done,
  output logic                   range_err,
  output logic [23:0]            sent_count,
  output logic [1:0]             dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] MAX_IDX = 6'(CHARSET_SIZE - 1);

  logic [1:0]                 state_q, state_d;
  logic [NUM_CHARS-1:0][5:0]  digit_q, digit_d;
  logic [5:0]                 to_q, to_d;
  logic [23:0]                count_q, count_d;
  logic                       err_q, err_d;

  logic run;
  logic lower_max;
  logic last;
  logic xfer;
  logic range_ok;
  logic carry;

  // Stream handshake: a candidate transfers on any rising edge where cand_valid
  // and cand_ready are both high; while valid is high and ready is low the
  // candidate and cand_last hold, and valid only drops after a transfer, on abort
  // or on reset.
  assign run      = (state_q == S_RUN);
  assign xfer     = run && cand_ready;
  assign range_ok = (from <= to) && (to <= MAX_IDX);

  always_comb begin
    lower_max = 1'b1;
    for (int i = 0; i < NUM_CHARS - 1; i++) begin
      if (digit_q[i] != MAX_IDX) lower_max = 1'b0;
    end
  end

  assign last = run && (digit_q[NUM_CHARS-1] == to_q) && lower_max;

  // Outside RUN the candidate bus is forced to zero rather than showing ASCII '0'.
  always_comb begin
    candidate = '0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (run) begin
        candidate[8*i +: 8] = (digit_q[i] < 6'd10) ? (8'h30 + {2'b00, digit_q[i]})
                                                   : (8'h37 + {2'b00, digit_q[i]});
      end
    end
  end

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    to_d    = to_q;
    count_d = count_q;
    err_d   = 1'b0;
    carry   = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (range_ok) begin
            state_d                = S_RUN;
            digit_d                = '0;
            digit_d[NUM_CHARS-1]   = from;
            to_d                   = to;
            count_d                = '0;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (xfer) begin
          count_d = count_q + 24'd1;
          if (last || abort) begin
            state_d = S_DONE;
          end else begin
            for (int i = 0; i < NUM_CHARS; i++) begin
              if (carry) begin
                if (digit_q[i] == MAX_IDX) begin
                  digit_d[i] = '0;
                end else begin
                  digit_d[i] = digit_q[i] + 6'd1;
                  carry      = 1'b0;
                end
              end
            end
          end
        end else if (abort) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      digit_q <= '0;
      to_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      to_q    <= to_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign cand_valid = run;
  assign cand_last  = last;
  assign busy       = run;
  assign done       = (state_q == S_DONE);
  assign range_err  = err_q;
  assign sent_count = count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_candidate_generator.sv
// Self-checking bench for candidate_generator: scoreboard of expected candidates,
// one task per scenario, single summary line at the end.
module tb_candidate_generator;

  // Three characters keep full-range runs short while exercising every rule.
  localparam int NC  = 3;
  localparam int W   = 8 * NC;
  localparam int PER = 36 ** (NC - 1);

  logic           clk;
  logic           rst;
  logic           start;
  logic [5:0]     from;
  logic [5:0]     to;
  logic           abort;
  logic           cand_ready;
  logic           cand_valid;
  logic [W-1:0]   candidate;
  logic           cand_last;
  logic           busy;
  logic           done;
  logic           range_err;
  logic [23:0]    sent_count;
  logic [1:0]     dbg_state;

  logic [W:0]     exp_q[$];
  int             vectors;
  int             errors;
  int             last_sent;

  candidate_generator #(.NUM_CHARS(NC), .CHARSET_SIZE(36)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .from       (from),
    .to         (to),
    .abort      (abort),
    .cand_ready (cand_ready),
    .cand_valid (cand_valid),
    .candidate  (candidate),
    .cand_last  (cand_last),
    .busy       (busy),
    .done       (done),
    .range_err  (range_err),
    .sent_count (sent_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ascii_of(input int first, input int rest);
    int           v;
    int           dig;
    logic [W-1:0] r;
    v = rest;
    r = '0;
    for (int i = 0; i < NC; i++) begin
      if (i == NC - 1) dig = first;
      else begin
        dig = v % 36;
        v   = v / 36;
      end
      r[8*i +: 8] = (dig < 10) ? 8'(48 + dig) : 8'(65 + dig - 10);
    end
    return r;
  endfunction

  task automatic push_range(input int f, input int t);
    for (int c = f; c <= t; c++) begin
      for (int r = 0; r < PER; r++) begin
        exp_q.push_back({(c == t) && (r == PER - 1), ascii_of(c, r)});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [5:0] f, input logic [5:0] t);
    @(negedge clk);
    from  = f;
    to    = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    from  = 6'($urandom_range(63));
    to    = 6'($urandom_range(63));
  endtask

  // Scoreboard monitor: pops one expected entry per transfer, checks stall hold.
  task automatic stream(input int ready_pct, input int abort_at, input int stop_at,
                        output int n, output int cyc, output logic [W:0] last_x);
    logic [W:0] held;
    logic [W:0] e;
    logic       stalled;
    n       = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    last_x  = '0;
    while (cand_valid && n != stop_at) begin
      if (cyc > 20000) begin
        vectors++; errors++;
        $display("FAIL stream_timeout: still valid after %0d cycles, required end", cyc);
        break;
      end
      if (stalled) begin
        vectors++;
        if ({cand_last, candidate} !== held) begin
          errors++;
          $display("FAIL stall_hold: got %h required %h", {cand_last, candidate}, held);
        end
      end
      cand_ready = ($urandom_range(99) < ready_pct);
      abort      = cand_ready && (n == abort_at);
      if (cand_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_candidate: got %h required none", candidate);
        end else begin
          e = exp_q.pop_front();
          if ({cand_last, candidate} !== e) begin
            errors++;
            $display("FAIL candidate[%0d]: got %h required %h", n, {cand_last, candidate}, e);
          end
        end
        last_x  = {cand_last, candidate};
        n++;
        stalled = 1'b0;
      end else begin
        held    = {cand_last, candidate};
        stalled = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    cand_ready = 1'b0;
    abort      = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cand_valid, cand_last, busy, done, range_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000",
               {cand_valid, cand_last, busy, done, range_err});
    end
    vectors++;
    if (candidate !== '0 || sent_count !== 24'd0) begin
      errors++;
      $display("FAIL reset_data: got cand %h count %0d required 0 0", candidate, sent_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_zero();
    int n, cyc;
    logic [W:0] lx;
    push_range(0, 0);
    do_start(6'd0, 6'd0);
    vectors++;
    if (candidate !== 24'h303030 || cand_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_000: got %h valid %b required 303030 1", candidate, cand_valid);
    end
    stream(100, -1, -1, n, cyc, lx);
    vectors++;
    if (lx !== {1'b1, 24'h305A5A}) begin
      errors++;
      $display("FAIL last_0ZZ: got %h required %h", lx, {1'b1, 24'h305A5A});
    end
    vectors++;
    if (cyc !== n) begin
      errors++;
      $display("FAIL no_bubbles: got %0d cycles required %0d", cyc, n);
    end
    vectors++;
    if ({done, busy, cand_valid, range_err} !== 4'b1000) begin
      errors++;
      $display("FAIL end_flags_0: got %b required 1000", {done, busy, cand_valid, range_err});
    end
    vectors++;
    if (sent_count !== 24'(PER) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL count_0: got %0d left %0d required %0d left 0", sent_count, exp_q.size(), PER);
    end
  endtask

  task automatic test_back_to_back();
    int n, cyc;
    logic [W:0] lx;
    push_range(35, 35);
    do_start(6'd35, 6'd35);
    vectors++;
    if (candidate !== 24'h5A3030 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_Z00: got %h busy %b required 5a3030 1", candidate, busy);
    end
    stream(100, -1, -1, n, cyc, lx);
    vectors++;
    if (lx !== {1'b1, 24'h5A5A5A}) begin
      errors++;
      $display("FAIL last_ZZZ: got %h required %h", lx, {1'b1, 24'h5A5A5A});
    end
    vectors++;
    if (sent_count !== 24'(PER) || done !== 1'b1) begin
      errors++;
      $display("FAIL count_35: got %0d done %b required %0d 1", sent_count, done, PER);
    end
  endtask

  task automatic test_range_9_10();
    int n, cyc;
    logic [W:0] lx;
    push_range(9, 10);
    do_start(6'd9, 6'd10);
    stream(100, -1, -1, n, cyc, lx);
    vectors++;
    if (lx !== {1'b1, 24'h415A5A} || sent_count !== 24'(2 * PER)) begin
      errors++;
      $display("FAIL end_9_10: got %h count %0d required %h %0d",
               lx, sent_count, {1'b1, 24'h415A5A}, 2 * PER);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || sent_count !== 24'(2 * PER)) begin
      errors++;
      $display("FAIL done_width: got done %b count %0d required 0 %0d", done, sent_count, 2 * PER);
    end
  endtask

  task automatic test_backpressure();
    int n, cyc;
    logic [W:0] lx;
    push_range(2, 3);
    do_start(6'd2, 6'd3);
    stream(60, -1, -1, n, cyc, lx);
    vectors++;
    if (sent_count !== 24'(n) || n != 2 * PER || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_count: got %0d xfers %0d left %0d required %0d", sent_count, n,
               exp_q.size(), 2 * PER);
    end
    vectors++;
    if (cyc <= n || done !== 1'b1) begin
      errors++;
      $display("FAIL bp_stalls: got cycles %0d done %b required > %0d 1", cyc, done, n);
    end
    last_sent = 2 * PER;
  endtask

  task automatic test_invalid(input logic [5:0] f, input logic [5:0] t);
    logic seen;
    do_start(f, t);
    vectors++;
    if ({done, range_err, cand_valid} !== 3'b110) begin
      errors++;
      $display("FAIL invalid_%0d_%0d: got %b required 110", f, t, {done, range_err, cand_valid});
    end
    from  = 6'd0;
    to    = 6'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    repeat (4) begin
      if (cand_valid || done || range_err) seen = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (seen !== 1'b0 || sent_count !== 24'(last_sent)) begin
      errors++;
      $display("FAIL start_in_done: got activity %b count %0d required 0 %0d",
               seen, sent_count, last_sent);
    end
  endtask

  task automatic test_abort();
    int n, cyc;
    logic [W:0] lx;
    logic seen;
    push_range(0, 0);
    do_start(6'd0, 6'd0);
    stream(100, 38, -1, n, cyc, lx);
    exp_q.delete();
    vectors++;
    if (n != 39 || sent_count !== 24'd39 || lx[W-1:0] !== 24'h303132) begin
      errors++;
      $display("FAIL abort_count: got %0d xfers %0d last %h required 39 303132",
               sent_count, n, lx[W-1:0]);
    end
    vectors++;
    if ({done, cand_valid, range_err} !== 3'b100) begin
      errors++;
      $display("FAIL abort_done: got %b required 100", {done, cand_valid, range_err});
    end
    cand_ready = 1'b1;
    seen       = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (cand_valid) seen = 1'b1;
    end
    cand_ready = 1'b0;
    vectors++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: got valid %b required 0", seen);
    end
  endtask

  task automatic test_abort_stalled();
    do_start(6'd1, 6'd1);
    vectors++;
    if (candidate !== 24'h313030) begin
      errors++;
      $display("FAIL first_100: got %h required 313030", candidate);
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if ({done, cand_valid} !== 2'b10 || sent_count !== 24'd0) begin
      errors++;
      $display("FAIL abort_stalled: got %b count %0d required 10 0", {done, cand_valid}, sent_count);
    end
  endtask

  task automatic test_reset_mid_run();
    int n, cyc;
    logic [W:0] lx;
    push_range(0, 0);
    do_start(6'd0, 6'd0);
    stream(100, -1, 100, n, cyc, lx);
    vectors++;
    if (sent_count !== 24'd100 || cand_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got %0d valid %b required 100 1", sent_count, cand_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({cand_valid, cand_last, busy, done, range_err} !== 5'b0 || candidate !== '0 ||
        sent_count !== 24'd0) begin
      errors++;
      $display("FAIL async_reset: got %b %h %0d required 00000 000000 0",
               {cand_valid, cand_last, busy, done, range_err}, candidate, sent_count);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    push_range(4, 7);
    do_start(6'd4, 6'd7);
    vectors++;
    if (candidate !== 24'h343030 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_400: got %h busy %b required 343030 1", candidate, busy);
    end
    stream(100, -1, 5, n, cyc, lx);
    exp_q.delete();
    vectors++;
    if (sent_count !== 24'd5) begin
      errors++;
      $display("FAIL count_4_7: got %0d required 5", sent_count);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors    = 0;
    errors     = 0;
    last_sent  = 0;
    rst        = 1'b1;
    start      = 1'b0;
    from       = '0;
    to         = '0;
    abort      = 1'b0;
    cand_ready = 1'b0;
    test_reset();
    test_full_zero();
    test_back_to_back();
    test_range_9_10();
    test_backpressure();
    test_invalid(6'd5, 6'd3);
    test_invalid(6'd0, 6'd36);
    test_abort();
    test_abort_stalled();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
